sort_slot_scheduler: RTL

SORT_SLOT_SCHEDULER -- requirements
Module: sort_slot_scheduler

---
 rtl/sort_slot_scheduler_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/sort_slot_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sort_slot_scheduler_pkg.sv
// Shared types and defaults for the sort slot scheduler: lane geometry helper,
// default sizing and the slot FSM state encoding.
package sort_slot_scheduler_pkg;

  localparam int unsigned PORT_NUB_TOTAL  = 8;
  localparam int unsigned DATA_WIDTH_DFLT = 32;
  localparam int unsigned SORT_LAT_DFLT   = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  // Lane layout is {valid, dest, data}, MSB first.
  function automatic int unsigned lane_width(input int unsigned ports, input int unsigned dw);
    return 1 + $clog2(ports) + dw;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one request: lowest set index at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned N  = 8,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_c
);

  logic          found_c;
  logic [PW-1:0] idx_c;

  // N is a power of two, so truncating ptr+off gives the modulo wrap.
  always_comb begin
    gnt_c   = '0;
    found_c = 1'b0;
    idx_c   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx_c = ptr + PW'(off);
      if (!found_c && req[idx_c]) begin
        gnt_c[idx_c] = 1'b1;
        found_c      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sort_slot_scheduler.sv
// Collects per-port requests into one-entry buffers, grants one request per
// destination each slot, and shepherds one slot at a time through the sorter.
module sort_slot_scheduler
  import sort_slot_scheduler_pkg::*;
#(
  parameter  int unsigned PORT_NUB    = PORT_NUB_TOTAL,
  parameter  int unsigned DATA_WIDTH  = DATA_WIDTH_DFLT,
  parameter  int unsigned SORT_LAT    = SORT_LAT_DFLT,
  localparam int unsigned PW          = $clog2(PORT_NUB),
  localparam int unsigned LW          = lane_width(PORT_NUB, DATA_WIDTH),
  localparam int unsigned WIDTH_TOTAL = PORT_NUB * LW
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORT_NUB-1:0]              in_valid,
  input  logic [PORT_NUB*PW-1:0]           in_dest,
  input  logic [PORT_NUB*DATA_WIDTH-1:0]   in_data,
  output logic [PORT_NUB-1:0]              in_ready,
  output logic [WIDTH_TOTAL-1:0]           sort_in,
  input  logic [WIDTH_TOTAL-1:0]           sort_out,
  output logic                             out_valid,
  output logic [WIDTH_TOTAL-1:0]           out_data,
  output logic                             busy
);

  localparam int unsigned CW = (SORT_LAT > 1) ? $clog2(SORT_LAT) : 1;

  state_e                  state_q, state_d;
  logic [PORT_NUB-1:0]     empty_q, empty_d;
  logic [PW-1:0]           dest_q [PORT_NUB];
  logic [PW-1:0]           dest_d [PORT_NUB];
  logic [DATA_WIDTH-1:0]   data_q [PORT_NUB];
  logic [DATA_WIDTH-1:0]   data_d [PORT_NUB];
  logic [PW-1:0]           rr_q   [PORT_NUB];
  logic [PW-1:0]           rr_d   [PORT_NUB];
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WIDTH_TOTAL-1:0]  sort_in_q, sort_in_d;
  logic [WIDTH_TOTAL-1:0]  out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;

  logic [PORT_NUB-1:0]     req_c [PORT_NUB];
  logic [PORT_NUB-1:0]     gnt_c [PORT_NUB];
  logic [PORT_NUB-1:0]     granted_c;

  // Per-destination request vectors: full buffers addressed to that destination.
  always_comb begin
    for (int d = 0; d < PORT_NUB; d++) begin
      req_c[d] = '0;
      for (int i = 0; i < PORT_NUB; i++) begin
        req_c[d][i] = !empty_q[i] && (dest_q[i] == PW'(d));
      end
    end
  end

  for (genvar g = 0; g < PORT_NUB; g++) begin : g_arb
    rr_arbiter #(.N(PORT_NUB)) u_rr_arbiter (
      .req   (req_c[g]),
      .ptr   (rr_q[g]),
      .gnt_c (gnt_c[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    empty_d     = empty_q;
    dest_d      = dest_q;
    data_d      = data_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    sort_in_d   = sort_in_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    granted_c   = '0;
    for (int d = 0; d < PORT_NUB; d++) begin
      granted_c = granted_c | gnt_c[d];
    end

    // Acceptance only targets empty buffers, so it never collides with a grant.
    for (int i = 0; i < PORT_NUB; i++) begin
      if (in_valid[i] && empty_q[i]) begin
        empty_d[i] = 1'b0;
        dest_d[i]  = in_dest[i*PW +: PW];
        data_d[i]  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!(&empty_q)) state_d = ST_ARB;
      end
      ST_ARB: begin
        for (int i = 0; i < PORT_NUB; i++) begin
          sort_in_d[i*LW +: LW] = granted_c[i] ? {1'b1, dest_q[i], data_q[i]} : LW'(0);
          if (granted_c[i]) empty_d[i] = 1'b1;
        end
        for (int d = 0; d < PORT_NUB; d++) begin
          for (int i = 0; i < PORT_NUB; i++) begin
            if (gnt_c[d][i]) rr_d[d] = PW'(i + 1);
          end
        end
        cnt_d   = CW'(SORT_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_CAPTURE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_CAPTURE: begin
        out_data_d  = sort_out;
        out_valid_d = 1'b1;
        state_d     = (&empty_q) ? ST_IDLE : ST_ARB;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      empty_q     <= '1;
      cnt_q       <= '0;
      sort_in_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < PORT_NUB; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
        rr_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      empty_q     <= empty_d;
      cnt_q       <= cnt_d;
      sort_in_q   <= sort_in_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      for (int i = 0; i < PORT_NUB; i++) begin
        dest_q[i] <= dest_d[i];
        data_q[i] <= data_d[i];
        rr_q[i]   <= rr_d[i];
      end
    end
  end

  assign in_ready  = empty_q;
  assign sort_in   = sort_in_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule
